// File: rtl/hlsm_loop_ctrl_if.sv
// hlsm_loop_ctrl_if
// Start/Done handshake bundle for the loop controller: operands, loop bounds,
// accumulated results and status. The controller connects through the slave
// modport. The requester, a top level or the testbench, uses master.
interface hlsm_loop_ctrl_if #(
    parameter int DATAW = 32,
    parameter int IW    = 8
);
    logic             Start;
    logic [DATAW-1:0] a;
    logic [DATAW-1:0] b;
    logic [DATAW-1:0] c;
    logic [IW-1:0]    Lo;
    logic [IW-1:0]    Hi;
    logic [DATAW-1:0] z;
    logic [DATAW-1:0] x;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, a, b, c, Lo, Hi,
        input  z, x, Busy, Done
    );

    modport slave (
        input  Start, a, b, c, Lo, Hi,
        output z, x, Busy, Done
    );
endinterface

// File: rtl/hlsm_loop_ctrl.sv
// hlsm_loop_ctrl
// Loop-sequencing HLSM. It runs i from Lo up to, but not including, Hi.
// The loop body computes z += (a+b) and x += c. All of that arithmetic goes
// through one shared adder and one shared comparator, one operation per state.
// Optional feature: defining HLSM_ITER_LIMIT_EN caps the trip count at
// MAX_ITER iterations.
module hlsm_loop_ctrl #(
    parameter int DATAW    = 32,
    parameter int IW       = 8,
    parameter int MAX_ITER = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    hlsm_loop_ctrl_if.slave bus
);

    // Width of the iteration counter. It only needs to reach MAX_ITER.
    localparam int NW = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_CHECK  = 3'd2,
        S_BODY1  = 3'd3,
        S_BODY2  = 3'd4,
        S_INCR   = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    state_t state;
    state_t state_next;

    // Copies of the request taken in IDLE. Nothing after IDLE looks at bus inputs.
    logic [DATAW-1:0] a_cap;
    logic [DATAW-1:0] b_cap;
    logic [DATAW-1:0] c_cap;
    logic [IW-1:0]    lo_cap;
    logic [IW-1:0]    hi_cap;

    // Loop state. i is one bit wider than the bounds so it can never overflow at Hi = max.
    logic [DATAW-1:0]    d;
    logic [DATAW-1:0]    z_acc;
    logic [DATAW-1:0]    x_acc;
    logic signed [IW:0]  i;
    logic signed [IW:0]  hi_ext;
    logic [NW-1:0]       n;

    // Shared resources
    logic [DATAW-1:0] add_op_a;
    logic [DATAW-1:0] add_op_b;
    logic [DATAW-1:0] add_sum;
    logic             loop_go;
    logic             busy;
    logic             done;

    assign hi_ext  = {hi_cap[IW-1], hi_cap};
    assign add_sum = add_op_a + add_op_b;

    // Shared comparator: decides whether another iteration runs
`ifdef HLSM_ITER_LIMIT_EN
    assign loop_go = (i < hi_ext) && (n < NW'(MAX_ITER));
`else
    assign loop_go = (i < hi_ext);
`endif

    assign bus.z    = z_acc;
    assign bus.x    = x_acc;
    assign bus.Busy = busy;
    assign bus.Done = done;

    // State register; reset returns to IDLE regardless of Start
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, status outputs and shared-adder operand steering
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        add_op_a   = '0;
        add_op_b   = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.Start) begin
                    state_next = S_INIT;
                end
            end
            S_INIT: begin
                add_op_a   = a_cap;
                add_op_b   = b_cap;
                state_next = S_CHECK;
            end
            S_CHECK: begin
                state_next = loop_go ? S_BODY1 : S_FINISH;
            end
            S_BODY1: begin
                add_op_a   = z_acc;
                add_op_b   = d;
                state_next = S_BODY2;
            end
            S_BODY2: begin
                add_op_a   = x_acc;
                add_op_b   = c_cap;
                state_next = S_INCR;
            end
            S_INCR: begin
                state_next = S_CHECK;
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers: capture in IDLE, then one adder result per state
    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_cap  <= '0;
            b_cap  <= '0;
            c_cap  <= '0;
            lo_cap <= '0;
            hi_cap <= '0;
            d      <= '0;
            z_acc  <= '0;
            x_acc  <= '0;
            i      <= '0;
            n      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        a_cap  <= bus.a;
                        b_cap  <= bus.b;
                        c_cap  <= bus.c;
                        lo_cap <= bus.Lo;
                        hi_cap <= bus.Hi;
                    end
                end
                S_INIT: begin
                    d     <= add_sum;
                    i     <= {lo_cap[IW-1], lo_cap};
                    z_acc <= '0;
                    x_acc <= '0;
                    n     <= '0;
                end
                S_BODY1: begin
                    z_acc <= add_sum;
                end
                S_BODY2: begin
                    x_acc <= add_sum;
                end
                S_INCR: begin
                    i <= i + {{IW{1'b0}}, 1'b1};
                    n <= n + NW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hlsm_loop_ctrl.sv
// tb_hlsm_loop_ctrl
// Directed bench for hlsm_loop_ctrl. Expected values are hand-computed
// from z = N*(a+b) and x = N*c. Done is counted in cycles after the edge
// that samples Start: cycle 1 is INIT, and Done is high in cycle 3 + 4N.
// Expectations for the capped run follow HLSM_ITER_LIMIT_EN.
module tb_hlsm_loop_ctrl;

    localparam int DATAW    = 32;
    localparam int IW       = 8;
    localparam int MAX_ITER = 16;

    logic Clk = 1'b0;
    logic Rst;
    int   assertCount = 0;
    int   failCount   = 0;
    int   cyc;
    int   doneSeen;

    hlsm_loop_ctrl_if #(.DATAW(DATAW), .IW(IW)) bus ();

    hlsm_loop_ctrl #(.DATAW(DATAW), .IW(IW), .MAX_ITER(MAX_ITER)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; Start is sampled on the next rising edge, and the task returns at the falling edge of cycle 1
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv,
                                 input logic [7:0] lo, input logic [7:0] hi);
        bus.a     = av;
        bus.b     = bv;
        bus.c     = cv;
        bus.Lo    = lo;
        bus.Hi    = hi;
        bus.Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        bus.Start = 1'b0;
    endtask

    task automatic waitDone(input int startCyc, output int doneCyc);
        doneCyc = startCyc;
        while (bus.Done !== 1'b1 && doneCyc < 1000) begin
            @(negedge Clk);
            doneCyc++;
        end
    endtask

    task automatic runCase(input string tag, input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv,
                           input logic [7:0] lo, input logic [7:0] hi,
                           input logic [31:0] expZ, input logic [31:0] expX, input int expCyc);
        int dc;
        applyStimulus(av, bv, cv, lo, hi);
        checkOutput({tag, "_busy_rise"}, 32'(bus.Busy), 32'd1);
        waitDone(1, dc);
        checkOutput({tag, "_done_cycle"}, 32'(dc), 32'(expCyc));
        checkOutput({tag, "_z"}, bus.z, expZ);
        checkOutput({tag, "_x"}, bus.x, expX);
        @(negedge Clk);
        checkOutput({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
        checkOutput({tag, "_busy_fall"}, 32'(bus.Busy), 32'd0);
        checkOutput({tag, "_z_hold"}, bus.z, expZ);
        checkOutput({tag, "_x_hold"}, bus.x, expX);
    endtask

    // Directed sequence
    initial begin
        Rst       = 1'b1;
        bus.Start = 1'b1;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.c     = $urandom;
        bus.Lo    = 8'($urandom);
        bus.Hi    = 8'($urandom);
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("reset_z", bus.z, 32'd0);
        checkOutput("reset_x", bus.x, 32'd0);
        checkOutput("reset_done", 32'(bus.Done), 32'd0);
        checkOutput("reset_busy", 32'(bus.Busy), 32'd0);
        Rst       = 1'b0;
        bus.Start = 1'b0;
        @(negedge Clk);
        checkOutput("idle_busy", 32'(bus.Busy), 32'd0);

        $display("[TB] basic and boundary runs");
        runCase("basic", 32'd2, 32'd3, 32'hFFFF_FFFF, 8'd0, 8'd3, 32'd15, 32'hFFFF_FFFD, 15);
        runCase("empty", 32'd4, 32'd4, 32'd4, 8'd5, 8'd5, 32'd0, 32'd0, 3);
        runCase("wrap", 32'h7FFF_FFFF, 32'd1, 32'd7, 8'hFE, 8'd1, 32'h8000_0000, 32'd21, 15);
        runCase("reversed", 32'd9, 32'd9, 32'd9, 8'd3, 8'hFC, 32'd0, 32'd0, 3);
        runCase("himax", 32'd1, 32'd1, 32'd1, 8'd120, 8'd127, 32'd14, 32'd7, 31);

        $display("[TB] Start and input changes while busy");
        applyStimulus(32'd10, 32'd5, 32'd3, 8'd0, 8'd2);
        bus.a     = 32'd999;
        bus.b     = 32'd777;
        bus.c     = 32'd555;
        bus.Lo    = 8'hCE;
        bus.Hi    = 8'd50;
        bus.Start = 1'b1;
        repeat (3) @(negedge Clk);
        bus.Start = 1'b0;
        waitDone(4, cyc);
        checkOutput("busy_start_done_cycle", 32'(cyc), 32'd11);
        checkOutput("busy_start_z", bus.z, 32'd30);
        checkOutput("busy_start_x", bus.x, 32'd6);
        @(negedge Clk);
        checkOutput("busy_start_no_restart", 32'(bus.Busy), 32'd0);

        $display("[TB] reset during second BODY1");
        applyStimulus(32'd2, 32'd3, 32'd1, 8'd0, 8'd3);
        repeat (6) @(negedge Clk);
        checkOutput("midrun_z_before", bus.z, 32'd5);
        checkOutput("midrun_x_before", bus.x, 32'd1);
        Rst = 1'b1;
        @(negedge Clk);
        checkOutput("midrun_rst_busy", 32'(bus.Busy), 32'd0);
        checkOutput("midrun_rst_z", bus.z, 32'd0);
        checkOutput("midrun_rst_x", bus.x, 32'd0);
        Rst      = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.Done === 1'b1) doneSeen++;
            @(negedge Clk);
        end
        checkOutput("midrun_no_done", 32'(doneSeen), 32'd0);

        $display("[TB] long range, iteration cap");
`ifdef HLSM_ITER_LIMIT_EN
        runCase("cap", 32'd1, 32'd0, 32'd2, 8'd0, 8'd100, 32'd16, 32'd32, 67);
`else
        runCase("cap", 32'd1, 32'd0, 32'd2, 8'd0, 8'd100, 32'd100, 32'd200, 403);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
